// File: rtl/fu_div_iter.sv
// Iterative restoring divider (RV32M DIV/DIVU/REM/REMU), one quotient bit per clock.
// Optional abort input enabled by defining FU_DIV_FLUSH_EN.
module fu_div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] tag_in,
`ifdef FU_DIV_FLUSH_EN
    input  logic             flush,
`endif
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] res,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem, r_quot, r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rem_mode, r_qneg, r_rneg;
    logic [TAG_W-1:0] r_tag;

    logic             w_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_special_res;
    logic [WIDTH:0]   w_rem_sh, w_diff;
    logic [WIDTH-1:0] w_rem_nx, w_quot_nx, w_q_fix, w_r_fix, w_final;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & A[WIDTH-1];
    assign w_b_neg  = w_signed & B[WIDTH-1];
    assign w_a_abs  = w_a_neg ? (~A + ONE) : A;
    assign w_b_abs  = w_b_neg ? (~B + ONE) : B;
    assign w_b_zero = (B == '0);
    assign w_ovf    = w_signed & (A == MIN) & (B == '1);

    // op[1] selects remainder; both corner cases resolve without iterating
    assign w_special_res = op[1] ? (w_b_zero ? A : '0) : (w_b_zero ? '1 : A);

    // Shifted partial remainder needs WIDTH+1 bits; the difference sign is then exact
    assign w_rem_sh  = {r_rem, r_quot[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_div};
    assign w_rem_nx  = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quot_nx = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

    assign w_q_fix = r_qneg ? (~r_quot + ONE) : r_quot;
    assign w_r_fix = r_rneg ? (~r_rem + ONE) : r_rem;
    assign w_final = r_rem_mode ? w_r_fix : w_q_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_rem_mode <= 1'b0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_tag      <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            res        <= '0;
            tag_out    <= '0;
        end else
`ifdef FU_DIV_FLUSH_EN
        if (flush) begin
            r_state <= StIdle;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else
`endif
        begin
            case (r_state)
                StCalc: begin
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        res     <= w_final;
                        tag_out <= r_tag;
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= StDone;
                    end else begin
                        r_rem  <= w_rem_nx;
                        r_quot <= w_quot_nx;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    finish <= 1'b0;
                    if (EN) begin
                        if (w_b_zero || w_ovf) begin
                            res     <= w_special_res;
                            tag_out <= tag_in;
                            finish  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_rem      <= '0;
                            r_quot     <= w_a_abs;
                            r_div      <= w_b_abs;
                            r_rem_mode <= op[1];
                            r_qneg     <= w_a_neg ^ w_b_neg;
                            r_rneg     <= w_a_neg;
                            r_tag      <= tag_in;
                            r_cnt      <= '0;
                            busy       <= 1'b1;
                            r_state    <= StCalc;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
